alu_arbiter: RTL and testbench

Shares one combinational 32-bit ALU (ports operandA/operandB/command in; result/carryout/zero/overflow out) between two requesters. Each requester has a valid/ready request channel; the arbiter grants round-robin, latches operands, drives the ALU for one cycle and captures its outputs. It returns them on a single tagged response channel. It sits between the two issuing datapath units and the shared ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU command codes and arbiter FSM state encoding
package alu_arbiter_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-request round-robin grant, reusable for any shared unit
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic pointer,
  output logic grant,
  output logic grant_valid
);

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = (valid0 && valid1) ? pointer : valid1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters, tagged response out
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cmd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_c_q, rsp_c_d, rsp_o_q, rsp_o_d, rsp_z_q, rsp_z_d;
  logic             grant, grant_valid;

  rr_arb2 u_rr_arb2 (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .pointer     (ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_c_d      = rsp_c_q;
    rsp_o_d      = rsp_o_q;
    rsp_z_d      = rsp_z_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          a_d        = grant ? req1_a : req0_a;
          b_d        = grant ? req1_b : req0_b;
          cmd_d      = grant ? req1_cmd : req0_cmd;
          id_d       = grant;
          ptr_d      = ~grant;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_c_d      = alu_carryout;
        rsp_o_d      = alu_overflow;
        rsp_z_d      = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cmd_q        <= 3'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_c_q      <= 1'b0;
      rsp_o_q      <= 1'b0;
      rsp_z_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q      <= rsp_c_d;
      rsp_o_q      <= rsp_o_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  // ALU inputs come straight from flops so the shared ALU never sees request-side glitches.
  assign alu_operandA = a_q;
  assign alu_operandB = b_q;
  assign alu_command  = cmd_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_c_q;
  assign rsp_overflow = rsp_o_q;
  assign rsp_zero     = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a reference model
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    alu_out_t    res;
    logic [32:0] s;
    res = '0;
    s   = '0;
    case (cmd)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        res.r = s[31:0]; res.c = s[32];
        res.o = (a[31] == b[31]) && (res.r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        res.r = s[31:0]; res.c = s[32];
        res.o = (a[31] != b[31]) && (res.r[31] != a[31]);
      end
      3'd2: res.r = a ^ b;
      3'd3: res.r = {31'd0, ($signed(a) < $signed(b))};
      3'd4: res.r = a & b;
      3'd5: res.r = ~(a & b);
      3'd6: res.r = ~(a | b);
      default: res.r = a | b;
    endcase
    res.z = (res.r == 32'd0);
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_cmd, req1_cmd;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carryout, rsp_overflow, rsp_zero;
  logic [31:0] rsp_result, alu_operandA, alu_operandB, alu_result;
  logic [2:0]  alu_command;
  logic        alu_carryout, alu_overflow, alu_zero;
  alu_out_t    alu_o;

  always #5 clk = ~clk;

  always_comb alu_o = alu_ref(alu_operandA, alu_operandB, alu_command);
  assign alu_result   = alu_o.r;
  assign alu_carryout = alu_o.c;
  assign alu_overflow = alu_o.o;
  assign alu_zero     = alu_o.z;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic rst_dut();
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cmd = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cmd = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-run model state: who gets the next tie, and how far the in-flight op has progressed.
  logic        pref, busy, e0, e1, g, hs0, hs1;
  int          age, stall;
  logic        exp_id;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_cmd;
  alu_out_t    exp_o;
  logic        ids[$];
  int          r0cnt, r1cnt;

  initial begin
    // Single ADD after reset
    rst_dut();
    #1;
    check("rst_ctl", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carryout, rsp_overflow, rsp_zero}), 64'd0);
    check("rst_data", 64'({rsp_result, alu_operandA}), 64'd0);
    check("rst_alu", 64'({alu_operandB, alu_command}), 64'd0);
    @(negedge clk);
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd3; req0_cmd = 3'd0; rsp_ready = 1;
    #1;
    check("d1_rdy", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; #1;
    check("d1_exec_rv", 64'(rsp_valid), 64'd0);
    check("d1_alu_ops", 64'({alu_operandA, alu_operandB}), {32'd1, 32'd3});
    @(negedge clk); #1;
    check("d1_rv", 64'(rsp_valid), 64'd1);
    check("d1_res", 64'({rsp_id, rsp_result}), 64'd4);
    check("d1_flags", 64'({rsp_carryout, rsp_overflow, rsp_zero}), 64'd0);
    @(negedge clk); #1;
    check("d1_rv_drop", 64'(rsp_valid), 64'd0);

    // Simultaneous requests: 0 first, then 1
    rst_dut();
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd7; req0_cmd = 3'd1;
    req1_valid = 1; req1_a = 32'd4; req1_b = 32'hFFFF_FFFE; req1_cmd = 3'd0;
    rsp_ready = 1;
    #1;
    check("d2_rdy_a", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; #1;
    check("d2_exec_rdy", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk); #1;
    check("d2_rsp0", 64'({rsp_valid, rsp_id, rsp_result}), {31'd0, 1'b1, 1'b0, 32'hFFFF_FFFE});
    @(negedge clk); #1;
    check("d2_rdy_b", 64'({req0_ready, req1_ready, rsp_valid}), 64'b010);
    @(negedge clk); req1_valid = 0; #1;
    @(negedge clk); #1;
    check("d2_rsp1", 64'({rsp_valid, rsp_id, rsp_result}), {31'd0, 1'b1, 1'b1, 32'd2});
    check("d2_flags1", 64'({rsp_carryout, rsp_overflow, rsp_zero}), 64'b100);

    // Both held valid: responses alternate 0,1,0,1
    rst_dut();
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F; req0_cmd = 3'd7;
    req1_valid = 1; req1_a = 32'hFF; req1_b = 32'h0F; req1_cmd = 3'd4;
    rsp_ready = 1; r0cnt = 0; r1cnt = 0; ids.delete();
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) r0cnt++;
      if (req1_ready) r1cnt++;
      if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
      @(negedge clk);
    end
    check("d3_ready_cnt", 64'({r0cnt[7:0], r1cnt[7:0]}), 64'h0202);
    check("d3_nrsp", 64'(ids.size()), 64'd4);
    if (ids.size() == 4) check("d3_ids", 64'({ids[0], ids[1], ids[2], ids[3]}), 64'b0101);

    // Stalled response then ADD 0+0 from requester 1
    rst_dut();
    req0_valid = 1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_cmd = 3'd0; rsp_ready = 0;
    #1;
    check("d4_rdy", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_a = 0; req1_b = 0; req1_cmd = 3'd0;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("d4_stall", 64'({rsp_valid, rsp_result, rsp_overflow, req0_ready, req1_ready}),
            {29'd0, 1'b1, 32'h8000_0000, 1'b1, 2'b00});
    end
    @(negedge clk); rsp_ready = 1; #1;
    check("d4_release", 64'({rsp_valid, req1_ready}), 64'b10);
    @(negedge clk); #1;
    check("d4_next_grant", 64'({rsp_valid, req1_ready}), 64'b01);
    @(negedge clk); req1_valid = 0; #1;
    @(negedge clk); #1;
    check("d5_zero", 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}), {29'd0, 3'b111, 32'd0});

    // Reset during EXEC drops the op
    rst_dut();
    req0_valid = 1; req0_a = 32'hA5A5_A5A5; req0_b = 32'hFFFF_0000; req0_cmd = 3'd2; rsp_ready = 1;
    #1;
    check("d6_rdy", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; #1;
    check("d6_exec_cmd", 64'(alu_command), 64'd2);
    #2 rst_n = 0;
    #1;
    check("d6_async", 64'({rsp_valid, alu_command, alu_operandA}), 64'd0);
    @(negedge clk); #1;
    check("d6_held", 64'({rsp_valid, rsp_result}), 64'd0);
    @(negedge clk);
    rst_n = 1;
    req1_valid = 1; req1_a = 32'hA5A5_A5A5; req1_b = 32'hFFFF_0000; req1_cmd = 3'd2;
    #1;
    check("d6_rdy1", 64'({req0_ready, req1_ready, rsp_valid}), 64'b010);
    @(negedge clk); req1_valid = 0; #1;
    @(negedge clk); #1;
    check("d6_rsp", 64'({rsp_valid, rsp_id, rsp_zero, rsp_result}), {29'd0, 3'b110, 32'h5A5A_A5A5});

    // Randomized traffic against the cycle model
    rst_dut();
    pref = 0; busy = 0; age = 0; stall = 0; hs0 = 0; hs1 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom % 3) != 0;
        req0_a = pick(); req0_b = pick(); req0_cmd = 3'($urandom);
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom % 3) != 0;
        req1_a = pick(); req1_b = pick(); req1_cmd = 3'($urandom);
      end
      if (stall > 0) begin
        stall--; rsp_ready = 0;
      end else if ($urandom % 10 == 0) begin
        stall = $urandom_range(1, 8); rsp_ready = 0;
      end else begin
        rsp_ready = ($urandom % 4) != 0;
      end
      #1;
      if (!busy) begin
        e0 = req0_valid && (!req1_valid || pref == 1'b0);
        e1 = req1_valid && (!req0_valid || pref == 1'b1);
        check("rnd_grant", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
        check("rnd_idle_rv", 64'(rsp_valid), 64'd0);
        if (e0 || e1) begin
          g      = e1;
          op_a   = g ? req1_a : req0_a;
          op_b   = g ? req1_b : req0_b;
          op_cmd = g ? req1_cmd : req0_cmd;
          exp_id = g;
          exp_o  = alu_ref(op_a, op_b, op_cmd);
          pref   = ~g;
          busy   = 1;
          age    = 1;
        end
      end else begin
        check("rnd_busy_rdy", 64'({req0_ready, req1_ready}), 64'd0);
        if (age == 1) begin
          check("rnd_exec_rv", 64'(rsp_valid), 64'd0);
          check("rnd_alu_in", 64'({alu_command, alu_operandA ^ alu_operandB}), 64'({op_cmd, op_a ^ op_b}));
          check("rnd_alu_a", 64'(alu_operandA), 64'(op_a));
          age = 2;
        end else begin
          check("rnd_rsp", 64'({rsp_valid, rsp_id, rsp_result}), 64'({1'b1, exp_id, exp_o.r}));
          check("rnd_flags", 64'({rsp_carryout, rsp_overflow, rsp_zero}), 64'({exp_o.c, exp_o.o, exp_o.z}));
          if (rsp_ready) busy = 0;
        end
      end
      hs0 = req0_ready;
      hs1 = req1_ready;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
